icb_master_agent: RTL and testbench

- ICB initiator that drives the bus consumed by icb_slave in the ICB-to-APB bridge.
- Accepts simple requests from a local client (CPU model or DMA) and issues them as ICB commands.
- Tracks outstanding transactions and returns in-order responses tagged with read/write type.
- Used as the bridge's bus driver in subsystem benches and as the production front-end for non-core masters.

---
 rtl/icb_master_agent_if.sv | 25 ++
 rtl/icb_master_agent.sv | 170 +++++++++++++++++
 tb/tb_icb_master_agent.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icb_master_agent_if.sv
// ICB command/response bus bundle between the master agent and an ICB slave.
interface icb_master_agent_if;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [63:0] icb_cmd_wdata;
  logic [7:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [63:0] icb_rsp_rdata;
  logic        icb_rsp_err;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
  );
endinterface

// File: rtl/icb_master_agent.sv
// ICB initiator: registered command stage, outstanding tracking, in-order typed responses.
// Optional response timeout watchdog enabled by defining ICB_MST_TIMEOUT_EN.
module icb_master_agent #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  input  logic               req_read,
  input  logic [63:0]        req_wdata,
  input  logic [7:0]         req_wmask,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [63:0]        resp_rdata,
  output logic               resp_read,
  output logic               resp_err,
  icb_master_agent_if.master icb,
  output logic               busy,
  output logic               unexp_rsp,
  output logic               timeout
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned InfW = CntW + 1;
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic                       cmd_valid_q;
  logic [31:0]                cmd_addr_q;
  logic                       cmd_read_q;
  logic [63:0]                cmd_wdata_q;
  logic [7:0]                 cmd_wmask_q;
  logic [CntW-1:0]            outst_q, outst_d;
  logic [MAX_OUTSTANDING-1:0] type_q;
  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                       resp_valid_q, resp_read_q, resp_err_q;
  logic [63:0]                resp_rdata_q;
  logic                       unexp_q;

  logic            req_hs, cmd_hs, rsp_hs, rsp_take, outst_zero;
  logic            push, pop, pop_type;
  logic [InfW-1:0] inflight;

  assign outst_zero = (outst_q == '0);
  assign inflight   = {1'b0, outst_q} + InfW'(cmd_valid_q);

  // The pending command is counted so its handshake can never overshoot the type FIFO.
  assign req_ready = !rst && (!cmd_valid_q || icb.icb_cmd_ready) &&
                     (inflight < InfW'(MAX_OUTSTANDING));
  assign icb.icb_rsp_ready = !rst && (!resp_valid_q || resp_ready);

  assign req_hs = req_valid && req_ready;
  assign cmd_hs = cmd_valid_q && icb.icb_cmd_ready;
  assign rsp_hs = icb.icb_rsp_valid && icb.icb_rsp_ready;

  // A response racing the first command's handshake belongs to that command.
  assign rsp_take = rsp_hs && (!outst_zero || cmd_hs);
  assign pop      = rsp_hs && !outst_zero;
  assign push     = cmd_hs && !(rsp_take && outst_zero);
  assign pop_type = outst_zero ? cmd_read_q : type_q[rd_ptr_q];

  always_comb begin
    outst_d  = outst_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (cmd_hs && !rsp_take) begin
      outst_d = outst_q + 1'b1;
    end else if (!cmd_hs && rsp_take) begin
      outst_d = outst_q - 1'b1;
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_read_q   <= 1'b0;
      cmd_wdata_q  <= '0;
      cmd_wmask_q  <= '0;
      outst_q      <= '0;
      type_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_read_q  <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      unexp_q      <= 1'b0;
    end else begin
      if (req_hs) begin
        cmd_valid_q <= 1'b1;
        cmd_addr_q  <= req_addr;
        cmd_read_q  <= req_read;
        cmd_wdata_q <= req_wdata;
        cmd_wmask_q <= req_wmask;
      end else if (cmd_hs) begin
        cmd_valid_q <= 1'b0;
      end
      if (push) begin
        type_q[wr_ptr_q] <= cmd_read_q;
      end
      outst_q  <= outst_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (rsp_take) begin
        resp_valid_q <= 1'b1;
        resp_read_q  <= pop_type;
        resp_err_q   <= icb.icb_rsp_err;
        resp_rdata_q <= pop_type ? icb.icb_rsp_rdata : '0;
      end else if (resp_ready) begin
        resp_valid_q <= 1'b0;
      end
      if (rsp_hs && !rsp_take) begin
        unexp_q <= 1'b1;
      end
    end
  end

`ifdef ICB_MST_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout_q;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (rsp_hs || outst_zero) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != ToW'(TIMEOUT_CYCLES)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_q || (to_cnt_d == ToW'(TIMEOUT_CYCLES));
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign icb.icb_cmd_valid = cmd_valid_q;
  assign icb.icb_cmd_addr  = cmd_addr_q;
  assign icb.icb_cmd_read  = cmd_read_q;
  assign icb.icb_cmd_wdata = cmd_wdata_q;
  assign icb.icb_cmd_wmask = cmd_wmask_q;

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_read  = resp_read_q;
  assign resp_err   = resp_err_q;
  assign unexp_rsp  = unexp_q;
  assign busy       = cmd_valid_q || !outst_zero || resp_valid_q;

endmodule

// File: tb/tb_icb_master_agent.sv
// Scoreboard bench for icb_master_agent; timeout checks follow ICB_MST_TIMEOUT_EN.
module tb_icb_master_agent;
  localparam int unsigned MaxOut   = 4;
  localparam int unsigned ToCycles = 8;
`ifdef ICB_MST_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic        clk, rst;
  logic        req_valid, req_ready, req_read;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid, resp_ready, resp_read, resp_err;
  logic [63:0] resp_rdata;
  logic        busy, unexp_rsp, timeout;

  icb_master_agent_if icb ();

  icb_master_agent #(
    .MAX_OUTSTANDING (MaxOut),
    .TIMEOUT_CYCLES  (ToCycles)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_read   (req_read),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_read  (resp_read),
    .resp_err   (resp_err),
    .icb        (icb),
    .busy       (busy),
    .unexp_rsp  (unexp_rsp),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_cmd    = 0;
  int n_resp   = 0;

  logic [104:0] exp_cmd[$];   // {addr, read, wdata, wmask}
  logic         exp_type[$];  // read flag of commands awaiting a bench response
  logic [65:0]  exp_resp[$];  // {read, rdata, err}

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {req_ready, resp_valid, resp_read, resp_err, icb.icb_cmd_valid,
                          icb.icb_cmd_read, icb.icb_rsp_ready, busy, unexp_rsp, timeout}, '0);
    check({tag, "_data"}, {resp_rdata, icb.icb_cmd_addr, icb.icb_cmd_wmask}, '0);
    check({tag, "_wdata"}, icb.icb_cmd_wdata, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send_req(input logic [31:0] a, input logic rd, input logic [63:0] wd,
                          input logic [7:0] wm, output int waits);
    waits     = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_read  = rd;
    req_wdata = wd;
    req_wmask = wm;
    @(negedge clk);
    while (!req_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    check("req_accept", waits < 100, 1'b1);
    if (req_ready) begin
      exp_cmd.push_back({a, rd, wd, wm});
      exp_type.push_back(rd);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic send_rsp(input logic [63:0] rdata, input logic err);
    int   waits;
    logic rd;
    waits         = 0;
    icb.icb_rsp_valid = 1'b1;
    icb.icb_rsp_rdata = rdata;
    icb.icb_rsp_err   = err;
    @(negedge clk);
    while (!icb.icb_rsp_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    check("rsp_accept", waits < 100, 1'b1);
    if (exp_type.size() != 0) begin
      rd = exp_type.pop_front();
      exp_resp.push_back({rd, rd ? rdata : 64'h0, err});
    end
    @(posedge clk);
    #1;
    icb.icb_rsp_valid = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && icb.icb_cmd_valid && icb.icb_cmd_ready) begin
        n_cmd++;
        check("cmd_queue", exp_cmd.size() != 0, 1'b1);
        if (exp_cmd.size() != 0) begin
          check("cmd_payload", {icb.icb_cmd_addr, icb.icb_cmd_read, icb.icb_cmd_wdata,
                                icb.icb_cmd_wmask}, exp_cmd.pop_front());
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && resp_valid && resp_ready) begin
        n_resp++;
        check("resp_queue", exp_resp.size() != 0, 1'b1);
        if (exp_resp.size() != 0) begin
          check("resp_payload", {resp_read, resp_rdata, resp_err}, exp_resp.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    int base_cmd, base_resp;
    rst               = 1'b0;
    req_valid         = 1'b0;
    req_addr          = '0;
    req_read          = 1'b0;
    req_wdata         = '0;
    req_wmask         = '0;
    resp_ready        = 1'b1;
    icb.icb_cmd_ready = 1'b1;
    icb.icb_rsp_valid = 1'b0;
    icb.icb_rsp_rdata = '0;
    icb.icb_rsp_err   = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Single write, response two cycles after the command.
    send_req(32'h2000_0010, 1'b0, 64'h1, 8'hFF, w);
    check("wr_cmd_latency", icb.icb_cmd_valid, 1'b1);
    idle(2);
    send_rsp(64'hDEAD, 1'b0);
    check("wr_resp_latency", resp_valid, 1'b1);
    idle(1);
    check("wr_busy_after", {busy, resp_valid}, 2'b00);
    idle(1);

    // Four back-to-back writes fill the outstanding window.
    base_cmd = n_cmd;
    for (int i = 1; i <= 4; i++) send_req(32'h2000_0100 + 32'(i * 8), 1'b0, 64'(i), 8'hFF, w);
    req_valid = 1'b1;
    req_addr  = 32'h2000_0200;
    req_read  = 1'b0;
    req_wdata = 64'h5;
    req_wmask = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_req_ready", req_ready, 1'b0);
      check("full_busy", busy, 1'b1);
    end
    check("full_cmd_count", n_cmd - base_cmd, 4);
    @(posedge clk);
    #1;
    send_rsp(64'h0, 1'b0);
    send_req(32'h2000_0200, 1'b0, 64'h5, 8'hFF, w);
    check("req5_wait", w, 0);
    for (int i = 0; i < 4; i++) send_rsp(64'h0, 1'b0);
    idle(3);
    check("full_busy_done", busy, 1'b0);

    // Command backpressure: payload must hold steady.
    base_cmd  = n_cmd;
    base_resp = n_resp;
    icb.icb_cmd_ready = 1'b0;
    send_req(32'h2000_0014, 1'b0, 64'h2, 8'h0F, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_stable", {icb.icb_cmd_valid, icb.icb_cmd_addr, icb.icb_cmd_wdata,
                             icb.icb_cmd_wmask}, {1'b1, 32'h2000_0014, 64'h2, 8'h0F});
    end
    @(posedge clk);
    #1 icb.icb_cmd_ready = 1'b1;
    idle(2);
    check("stall_one_cmd", n_cmd - base_cmd, 1);
    send_rsp(64'h0, 1'b0);
    idle(2);
    check("stall_one_resp", n_resp - base_resp, 1);

    // Read with error, client stalls the response; a second response must wait.
    base_resp = n_resp;
    send_req(32'h2000_0018, 1'b1, 64'h0, 8'h00, w);
    send_req(32'h2000_0020, 1'b1, 64'h0, 8'h00, w);
    idle(1);
    resp_ready = 1'b0;
    send_rsp(64'h3, 1'b1);
    icb.icb_rsp_valid = 1'b1;
    icb.icb_rsp_rdata = 64'h5;
    icb.icb_rsp_err   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_resp", {resp_valid, resp_read, resp_err, resp_rdata}, {3'b111, 64'h3});
      check("hold_rsp_ready", icb.icb_rsp_ready, 1'b0);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    send_rsp(64'h5, 1'b0);
    idle(2);
    check("hold_two_resp", n_resp - base_resp, 2);

    // Response with nothing outstanding.
    check("unexp_before", unexp_rsp, 1'b0);
    icb.icb_rsp_valid = 1'b1;
    icb.icb_rsp_rdata = 64'h77;
    @(negedge clk);
    check("unexp_rsp_ready", icb.icb_rsp_ready, 1'b1);
    @(posedge clk);
    #1 icb.icb_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("unexp_flag", {unexp_rsp, resp_valid, busy}, 3'b100);
      idle(1);
    end

    // Read that never gets a response: watchdog, then reset mid-wait.
    send_req(32'h2000_0028, 1'b1, 64'h0, 8'h00, w);
    @(posedge clk);
    #1;
    for (int i = 1; i <= ToCycles + 1; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("timeout_c%0d", i), timeout, ToEn && (i >= ToCycles));
    end
    check("timeout_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_type.delete();
    exp_resp.delete();
    exp_cmd.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Traffic after reset.
    send_req(32'h2000_0030, 1'b1, 64'h0, 8'h00, w);
    idle(1);
    send_rsp(64'hABCD, 1'b0);
    idle(2);
    check("final_cmd_count", n_cmd, 11);
    check("final_resp_count", n_resp, 10);
    check("final_queues", {exp_cmd.size() == 0, exp_resp.size() == 0, exp_type.size() == 0},
          3'b111);
    check("final_idle", {busy, unexp_rsp}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
